// File: rtl/ov7670_stream_gen_pkg.sv
// Purpose: shared types, default timing and RGB444->RGB565 packing for the OV7670 emulator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package ov7670_stream_gen_pkg;

  localparam int C_IMG_COLS_DEF    = 160;
  localparam int C_IMG_ROWS_DEF    = 120;
  localparam int C_NB_IMG_PXLS_DEF = 15;
  localparam int C_NB_BUF_DEF      = 12;
  localparam int C_PCLK_HALF_DEF   = 2;
  localparam int C_VSYNC_LINES_DEF = 3;
  localparam int C_VBP_LINES_DEF   = 17;
  localparam int C_VFP_LINES_DEF   = 10;
  localparam int C_HBLANK_PCLK_DEF = 144;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  // RGB444 {r,g,b} -> RGB565 {R5,G6,B5}; low colour bits replicate the MSBs.
  function automatic logic [15:0] pack565(input logic [11:0] px, input logic swap);
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    r = swap ? px[3:0]  : px[11:8];
    g = px[7:4];
    b = swap ? px[11:8] : px[3:0];
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Purpose: camera-pin bundle (pclk/vsync/href/d) plus frame_buffer read port (rd_addr/rd_data).
// Latency: rd_data is expected one clk after rd_addr.
// Backpressure: none; the sensor side is free-running.
interface ov7670_stream_gen_if #(
  parameter int C_NB_IMG_PXLS = 15,
  parameter int C_NB_BUF      = 12
);
  logic [C_NB_IMG_PXLS-1:0] rd_addr;
  logic [C_NB_BUF-1:0]      rd_data;
  logic                     pclk;
  logic                     vsync;
  logic                     href;
  logic [7:0]               d;

  // master: the emulator; slave: frame_buffer read port plus capture pins.
  modport master (output rd_addr, pclk, vsync, href, d, input rd_data);
  modport slave  (input rd_addr, pclk, vsync, href, d, output rd_data);
endinterface

// File: rtl/ov7670_stream_gen_pclk_gen.sv
// Purpose: divides clk into a free-running pclk and flags the clk cycle on which pclk falls.
// Latency: pclk toggles every C_PCLK_HALF clk cycles after reset release; tick is combinational.
// Backpressure: none. Ports: clk, rst (async, active-high), pclk, tick.
module ov7670_pclk_gen #(
  parameter int C_PCLK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pclk,
  output logic tick
);
  localparam int W = (C_PCLK_HALF > 1) ? $clog2(C_PCLK_HALF) : 1;

  logic [W-1:0] cnt;
  logic         wrap;

  assign wrap = (cnt == W'(C_PCLK_HALF - 1));
  // Registered updates taken on tick land on the same edge that drops pclk.
  assign tick = wrap & pclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      pclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      pclk <= ~pclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ov7670_stream_gen.sv
// Purpose: OV7670 RGB565 sensor emulator; streams a stored RGB444 image or test pattern on camera pins.
// Latency: pins change on pclk falling edges; rd_data is consumed one clk after rd_addr moves.
// Backpressure: none; en only gates frame starts. Ports: clk, rst, en, test_pattern, swap_r_b, busy, frame_done, cam (master).
module ov7670_stream_gen
  import ov7670_stream_gen_pkg::*;
#(
  parameter int C_IMG_COLS    = C_IMG_COLS_DEF,
  parameter int C_IMG_ROWS    = C_IMG_ROWS_DEF,
  parameter int C_NB_IMG_PXLS = C_NB_IMG_PXLS_DEF,
  parameter int C_NB_BUF      = C_NB_BUF_DEF,
  parameter int C_PCLK_HALF   = C_PCLK_HALF_DEF,
  parameter int C_VSYNC_LINES = C_VSYNC_LINES_DEF,
  parameter int C_VBP_LINES   = C_VBP_LINES_DEF,
  parameter int C_VFP_LINES   = C_VFP_LINES_DEF,
  parameter int C_HBLANK_PCLK = C_HBLANK_PCLK_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                test_pattern,
  input  logic                swap_r_b,
  output logic                busy,
  output logic                frame_done,
  ov7670_stream_gen_if.master cam
);
  localparam int LINE_PCLK = 2 * C_IMG_COLS + C_HBLANK_PCLK;
  localparam int MAX_LINES_A = (C_VSYNC_LINES > C_VBP_LINES) ? C_VSYNC_LINES : C_VBP_LINES;
  localparam int MAX_LINES_B = (C_IMG_ROWS > C_VFP_LINES) ? C_IMG_ROWS : C_VFP_LINES;
  localparam int MAX_LINES = (MAX_LINES_A > MAX_LINES_B) ? MAX_LINES_A : MAX_LINES_B;
  localparam int PCNT_W = $clog2(LINE_PCLK);
  localparam int LCNT_W = $clog2(MAX_LINES + 1);

  localparam logic [PCNT_W-1:0] LAST_P       = PCNT_W'(LINE_PCLK - 1);
  localparam logic [PCNT_W-1:0] ACT_P        = PCNT_W'(2 * C_IMG_COLS);
  localparam logic [LCNT_W-1:0] LAST_VSYNC_L = LCNT_W'(C_VSYNC_LINES - 1);
  localparam logic [LCNT_W-1:0] LAST_VBP_L   = LCNT_W'(C_VBP_LINES - 1);
  localparam logic [LCNT_W-1:0] LAST_ACT_L   = LCNT_W'(C_IMG_ROWS - 1);
  localparam logic [LCNT_W-1:0] LAST_VFP_L   = LCNT_W'(C_VFP_LINES - 1);

  logic                     tick;
  logic                     pclk_i;
  state_t                   state_q, state_n;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_n;   // pclk period within the line
  logic [LCNT_W-1:0]        lcnt_q, lcnt_n;   // line within the current state
  logic [LCNT_W-1:0]        last_line;
  logic                     frame_end;
  logic [C_NB_BUF-1:0]      fetch;
  logic                     act_n, byte0_n, byte1_n;
  logic [3:0]               col4, row4;
  logic [11:0]              pixel;
  logic [15:0]              px565;
  logic [7:0]               d_n;
  logic [C_NB_IMG_PXLS-1:0] addr_n;
  logic                     vsync_q, href_q, frame_done_q;
  logic [7:0]               d_q, byte1_q;
  logic [C_NB_IMG_PXLS-1:0] rd_addr_q;

  ov7670_pclk_gen #(.C_PCLK_HALF(C_PCLK_HALF)) u_pclk_gen (
    .clk  (clk),
    .rst  (rst),
    .pclk (pclk_i),
    .tick (tick)
  );

  // State register: FSM and position counters only move on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      lcnt_q  <= '0;
    end else if (tick) begin
      state_q <= state_n;
      pcnt_q  <= pcnt_n;
      lcnt_q  <= lcnt_n;
    end
  end

  // Next state: position of the pclk period launched by the coming tick.
  always_comb begin : next_state
    state_n   = state_q;
    pcnt_n    = pcnt_q;
    lcnt_n    = lcnt_q;
    frame_end = 1'b0;
    last_line = '0;
    case (state_q)
      ST_VSYNC:  last_line = LAST_VSYNC_L;
      ST_VBP:    last_line = LAST_VBP_L;
      ST_ACTIVE: last_line = LAST_ACT_L;
      ST_VFP:    last_line = LAST_VFP_L;
      default:   last_line = '0;
    endcase
    if (state_q == ST_IDLE) begin
      if (en) begin
        state_n = ST_VSYNC;
        pcnt_n  = '0;
        lcnt_n  = '0;
      end
    end else if (pcnt_q != LAST_P) begin
      pcnt_n = pcnt_q + 1'b1;
    end else begin
      pcnt_n = '0;
      if (lcnt_q != last_line) begin
        lcnt_n = lcnt_q + 1'b1;
      end else begin
        lcnt_n = '0;
        case (state_q)
          ST_VSYNC:  state_n = ST_VBP;
          ST_VBP:    state_n = ST_ACTIVE;
          ST_ACTIVE: state_n = ST_VFP;
          ST_VFP: begin
            // en is only honoured here, so a dropped en lets the frame finish.
            frame_end = 1'b1;
            state_n   = en ? ST_VSYNC : ST_IDLE;
          end
          default:   state_n = ST_IDLE;
        endcase
      end
    end
  end

  assign fetch = cam.rd_data;

  // Outputs: pin values for the period being launched. Even active periods
  // carry byte0 and sample the pixel; odd ones replay the held byte1.
  always_comb begin : outputs
    act_n   = (state_n == ST_ACTIVE) && (pcnt_n < ACT_P);
    byte0_n = act_n & ~pcnt_n[0];
    byte1_n = act_n & pcnt_n[0];
    col4    = 4'(pcnt_n >> 1);
    row4    = 4'(lcnt_n);
    pixel   = test_pattern ? {col4, row4, 4'h0} : 12'(fetch);
    px565   = pack565(pixel, swap_r_b);
    d_n     = 8'h00;
    if (byte0_n) begin
      d_n = px565[15:8];
    end else if (byte1_n) begin
      d_n = byte1_q;
    end
    addr_n = rd_addr_q;
    if ((state_n == ST_VBP) && (state_q != ST_VBP)) begin
      addr_n = '0;
    end else if (byte1_n) begin
      // Advancing on byte1 leaves a full byte period for the read to return.
      addr_n = rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      d_q          <= 8'h00;
      byte1_q      <= 8'h00;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= tick & frame_end;
      if (tick) begin
        vsync_q   <= (state_n == ST_VSYNC);
        href_q    <= act_n;
        d_q       <= d_n;
        rd_addr_q <= addr_n;
        if (byte0_n) begin
          byte1_q <= px565[7:0];
        end
      end
    end
  end

  assign cam.pclk    = pclk_i;
  assign cam.vsync   = vsync_q;
  assign cam.href    = href_q;
  assign cam.d       = d_q;
  assign cam.rd_addr = rd_addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Purpose: scoreboard bench for ov7670_stream_gen on a 4x2 frame (HBLANK=4, VSYNC/VBP/VFP=1, HALF=1).
// Latency: expected bytes are queued per frame and popped at each pclk rising edge with href high.
// Backpressure: n/a; all waits on the DUT are bounded by cycle budgets.
module tb_ov7670_stream_gen;

  typedef struct packed {
    logic [7:0]  d;
    logic [14:0] addr;
  } exp_t;

  logic clk;
  logic rst;
  logic en;
  logic test_pattern;
  logic swap_r_b;
  logic busy;
  logic frame_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_on = 1'b0;
  exp_t sb_q[$];
  int   fd_count = 0;
  int   href_pulses = 0;

  logic [11:0] mem [16];
  logic [11:0] px_f2 [4] = '{12'hF80, 12'hFFF, 12'h000, 12'h0F0};
  logic [15:0] exp_f2 [4] = '{16'hFC40, 16'hFFFF, 16'h0000, 16'h07E0};
  logic [15:0] exp_f3 [4] = '{16'h045F, 16'hFFFF, 16'h0000, 16'h07E0};

  ov7670_stream_gen_if #(.C_NB_IMG_PXLS(15), .C_NB_BUF(12)) cam ();

  ov7670_stream_gen #(
    .C_IMG_COLS(4), .C_IMG_ROWS(2), .C_NB_IMG_PXLS(15), .C_NB_BUF(12),
    .C_PCLK_HALF(1), .C_VSYNC_LINES(1), .C_VBP_LINES(1), .C_VFP_LINES(1),
    .C_HBLANK_PCLK(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .test_pattern (test_pattern),
    .swap_r_b     (swap_r_b),
    .busy         (busy),
    .frame_done   (frame_done),
    .cam          (cam)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read frame buffer model.
  always @(posedge clk) cam.rd_data <= mem[cam.rd_addr[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_px(input logic [7:0] b0, input logic [7:0] b1, input int i);
    exp_t e;
    e.d = b0; e.addr = 15'(i);     sb_q.push_back(e);
    e.d = b1; e.addr = 15'(i + 1); sb_q.push_back(e);
  endtask

  task automatic wait_fd();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    if (k == 400) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_frame_done: no pulse within 400 clk");
    end
  endtask

  task automatic wait_href();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cam.href) break;
    end
    if (k == 200) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_href: href not seen within 200 clk");
    end
  endtask

  // Receiver-side monitor: samples pins where pclk has just risen.
  logic pclk_prev;
  int   vs_len, hr_len;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !mon_on) begin
      pclk_prev = 1'b0;
      vs_len    = 0;
      hr_len    = 0;
    end else begin
      if (cam.pclk && !pclk_prev) begin
        if (cam.vsync) vs_len++;
        else if (vs_len != 0) begin
          check("vsync_len_pclk", vs_len, 12);
          vs_len = 0;
        end
        if (cam.href) begin
          hr_len++;
          if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_byte: got %0h with empty scoreboard", cam.d);
          end else begin
            e = sb_q.pop_front();
            check("d_byte", cam.d, e.d);
            check("rd_addr", cam.rd_addr, e.addr);
          end
        end else if (hr_len != 0) begin
          check("href_len_pclk", hr_len, 8);
          hr_len = 0;
          href_pulses++;
        end
      end
      pclk_prev = cam.pclk;
    end
  end

  // frame_done spacing: 60 pclk = 120 clk for back-to-back frames.
  int cyc = 0, last_fd = 0;
  logic have_last = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst || !mon_on) have_last = 1'b0;
    else if (frame_done) begin
      if (have_last) check("frame_period_clk", cyc - last_fd, 120);
      last_fd   = cyc;
      have_last = 1'b1;
      fd_count++;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; test_pattern = 1'b0; swap_r_b = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = px_f2[i % 4];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-line.
    en = 1'b1;
    wait_href();
    repeat (3) @(negedge clk);
    check("pre_rst_href", cam.href, 1);
    rst = 1'b1;
    #1;
    check("rst_pclk", cam.pclk, 0);
    check("rst_vsync", cam.vsync, 0);
    check("rst_href", cam.href, 0);
    check("rst_d", cam.d, 0);
    check("rst_rd_addr", cam.rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_vsync", cam.vsync, 0);

    // F1: data = address.
    for (int i = 0; i < 16; i++) mem[i] = 12'(i);
    for (int i = 0; i < 8; i++) push_px(8'h00, 8'(2 * i), i);
    mon_on = 1'b1;
    en = 1'b1;
    wait_fd();

    // F2: packing vectors, no swap.
    for (int i = 0; i < 16; i++) mem[i] = px_f2[i % 4];
    for (int i = 0; i < 8; i++) push_px(exp_f2[i % 4][15:8], exp_f2[i % 4][7:0], i);
    wait_fd();

    // F3: same vectors with red/blue swapped.
    swap_r_b = 1'b1;
    for (int i = 0; i < 8; i++) push_px(exp_f3[i % 4][15:8], exp_f3[i % 4][7:0], i);
    wait_fd();

    // F4: internal test pattern {col,row,0}.
    swap_r_b = 1'b0;
    test_pattern = 1'b1;
    for (int i = 0; i < 8; i++) push_px(8'(16 * (i % 4)), (i / 4 == 1) ? 8'h80 : 8'h00, i);
    wait_fd();

    // F5: en dropped during the first active row; frame must still finish.
    test_pattern = 1'b0;
    for (int i = 0; i < 8; i++) push_px(exp_f2[i % 4][15:8], exp_f2[i % 4][7:0], i);
    wait_href();
    en = 1'b0;
    wait_fd();
    repeat (50) @(negedge clk);
    check("end_busy", busy, 0);
    check("end_vsync", cam.vsync, 0);
    check("end_href", cam.href, 0);
    check("frame_done_count", fd_count, 5);
    check("href_pulse_count", href_pulses, 10);
    check("scoreboard_left", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
